// File: rtl/ex_mem_flag_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_flag_stage
//   EX/MEM pipeline register behind the 16-bit execute ALU, together with the
//   architectural {Z,V,N} flag register and the conditional-branch resolver.
//
//   Optional feature macro: FLAG_BYPASS_EN
//     defined   : branch resolution sees the flag values being written by the
//                 instruction currently in EX (same-cycle resolution).
//     undefined : branch resolution sees only the flag register.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ex_*              instruction fields arriving from EX
//   stall, flush      hazard-unit hold / bubble insert (flush wins)
//   br_eval, br_cond  branch evaluation request and condition code
//   br_taken          combinational branch decision (0 when br_eval=0)
//   flags             {Z,V,N} flag register
//   mem_*             registered EX/MEM fields
// ---------------------------------------------------------------------------
module ex_mem_flag_stage #(
   parameter int WIDTH      = 16,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   input  logic [3:0]            ex_alu_ctrl,
   input  logic [WIDTH-1:0]      ex_alu_out,
   input  logic                  ex_v,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_wr,
   input  logic                  ex_mem_rd,
   input  logic                  ex_mem_wr,
   input  logic [WIDTH-1:0]      ex_store_data,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  br_eval,
   input  logic [2:0]            br_cond,
   output logic                  br_taken,
   output logic [2:0]            flags,
   output logic                  mem_valid,
   output logic [WIDTH-1:0]      mem_alu_out,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_reg_wr,
   output logic                  mem_mem_rd,
   output logic                  mem_mem_wr,
   output logic [WIDTH-1:0]      mem_store_data
);

   // Flag bit positions inside {Z,V,N}
   localparam int FZ = 2;
   localparam int FV = 1;
   localparam int FN = 0;

   logic                  mem_valid_r;
   logic [WIDTH-1:0]      mem_alu_out_r;
   logic [REG_ADDR_W-1:0] mem_rd_r;
   logic                  mem_reg_wr_r;
   logic                  mem_mem_rd_r;
   logic                  mem_mem_wr_r;
   logic [WIDTH-1:0]      mem_store_data_r;
   logic [2:0]            flags_r;

   logic                  capture_s;
   logic                  upd_all_s;
   logic                  upd_z_s;
   logic [2:0]            flags_nxt_s;
   logic [2:0]            br_flags_s;
   logic                  br_taken_s;

   // {Z,V,N} as produced by the current ALU result
   function automatic logic [2:0] derive_flags(input logic [WIDTH-1:0] res,
                                               input logic             v);
      derive_flags = {(res == {WIDTH{1'b0}}), v, res[WIDTH-1]};
   endfunction

   // Decode which flag bits the EX instruction writes on this edge
   always_comb begin
      capture_s = ~flush & ~stall;
      upd_all_s = 1'b0;
      upd_z_s   = 1'b0;
      case (ex_alu_ctrl)
         4'b0000, 4'b0010:                                 upd_all_s = 1'b1;
         4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111:      upd_z_s   = 1'b1;
         default: begin
            upd_all_s = 1'b0;
            upd_z_s   = 1'b0;
         end
      endcase
   end

   // Next flag value; equals the register when no update happens this edge
   always_comb begin
      flags_nxt_s = flags_r;
      if (capture_s && ex_valid) begin
         if (upd_all_s) begin
            flags_nxt_s = derive_flags(ex_alu_out, ex_v);
         end else if (upd_z_s) begin
            flags_nxt_s[FZ] = (ex_alu_out == {WIDTH{1'b0}});
         end else begin
            flags_nxt_s = flags_r;
         end
      end else begin
         flags_nxt_s = flags_r;
      end
   end

   // Flag source for branch resolution
   always_comb begin
`ifdef FLAG_BYPASS_EN
      br_flags_s = flags_nxt_s;
`else
      br_flags_s = flags_r;
`endif
   end

   // Branch condition evaluation
   always_comb begin
      br_taken_s = 1'b0;
      if (br_eval) begin
         case (br_cond)
            3'b000:  br_taken_s = ~br_flags_s[FZ];
            3'b001:  br_taken_s =  br_flags_s[FZ];
            3'b010:  br_taken_s = ~br_flags_s[FZ] & ~br_flags_s[FN];
            3'b011:  br_taken_s =  br_flags_s[FN];
            3'b100:  br_taken_s =  br_flags_s[FZ] | ~br_flags_s[FN];
            3'b101:  br_taken_s =  br_flags_s[FZ] |  br_flags_s[FN];
            3'b110:  br_taken_s =  br_flags_s[FV];
            3'b111:  br_taken_s =  1'b1;
            default: br_taken_s =  1'b0;
         endcase
      end else begin
         br_taken_s = 1'b0;
      end
   end

   // EX/MEM pipeline register: flush clears control, stall holds everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid_r      <= 1'b0;
         mem_alu_out_r    <= {WIDTH{1'b0}};
         mem_rd_r         <= {REG_ADDR_W{1'b0}};
         mem_reg_wr_r     <= 1'b0;
         mem_mem_rd_r     <= 1'b0;
         mem_mem_wr_r     <= 1'b0;
         mem_store_data_r <= {WIDTH{1'b0}};
      end else if (flush) begin
         mem_valid_r      <= 1'b0;
         mem_reg_wr_r     <= 1'b0;
         mem_mem_rd_r     <= 1'b0;
         mem_mem_wr_r     <= 1'b0;
      end else if (!stall) begin
         mem_valid_r      <= ex_valid;
         mem_alu_out_r    <= ex_alu_out;
         mem_rd_r         <= ex_rd;
         mem_reg_wr_r     <= ex_reg_wr & ex_valid;
         mem_mem_rd_r     <= ex_mem_rd & ex_valid;
         mem_mem_wr_r     <= ex_mem_wr & ex_valid;
         mem_store_data_r <= ex_store_data;
      end
   end

   // Architectural flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_r <= 3'b000;
      end else begin
         flags_r <= flags_nxt_s;
      end
   end

   assign mem_valid      = mem_valid_r;
   assign mem_alu_out    = mem_alu_out_r;
   assign mem_rd         = mem_rd_r;
   assign mem_reg_wr     = mem_reg_wr_r;
   assign mem_mem_rd     = mem_mem_rd_r;
   assign mem_mem_wr     = mem_mem_wr_r;
   assign mem_store_data = mem_store_data_r;
   assign flags          = flags_r;
   assign br_taken       = br_taken_s;

endmodule

// File: doc/ex_mem_flag_stage.md
Name: ex_mem_flag_stage

Overview:
- Sits directly downstream of the 16-bit execute ALU.
- Registers the ALU result and the control fields that travel with it into the EX/MEM pipeline register.
- Holds the architectural Z/V/N flag register and updates it per opcode class.
- Resolves conditional branches from the flag state.
- Supports stall (hold) and flush (bubble insert) from the hazard unit.

Parameters:
WIDTH, 16, datapath width of ALU result and store data
REG_ADDR_W, 4, destination register index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
ex_valid  input  1  instruction in EX is real (not a bubble)
ex_alu_ctrl  input  4  ALU operation code of the EX instruction
ex_alu_out  input  WIDTH  ALU result
ex_v  input  1  ALU saturating-overflow flag
ex_rd  input  REG_ADDR_W  destination register
ex_reg_wr  input  1  writes register file
ex_mem_rd  input  1  load
ex_mem_wr  input  1  store
ex_store_data  input  WIDTH  store data
stall  input  1  hold EX/MEM register and flags
flush  input  1  insert bubble into EX/MEM
br_eval  input  1  branch in ID requests evaluation
br_cond  input  3  branch condition code
br_taken  output  1  branch condition satisfied
flags  output  3  {Z,V,N} flag register
mem_valid  output  1  EX/MEM holds a real instruction
mem_alu_out  output  WIDTH  registered ALU result
mem_rd  output  REG_ADDR_W  registered destination
mem_reg_wr  output  1  registered reg-write (forced 0 when bubble)
mem_mem_rd  output  1  registered load (forced 0 when bubble)
mem_mem_wr  output  1  registered store (forced 0 when bubble)
mem_store_data  output  WIDTH  registered store data

Behaviour:
- Reset: while rst=1, asynchronously clear every register output (mem_valid, mem_alu_out, mem_rd, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_store_data) and flags=3'b000. Reset asserted mid-stall or mid-flush still clears everything.
- Priority each edge: rst > flush > stall > normal capture.
- Normal (no stall, no flush): all mem_* outputs take their ex_* values one cycle later (latency 1). mem_valid=ex_valid. When ex_valid=0, mem_reg_wr, mem_mem_rd and mem_mem_wr are captured as 0.
- Stall=1, flush=0: EX/MEM register and flags hold. No flag update.
- Flush=1 (regardless of stall): mem_valid, mem_reg_wr, mem_mem_rd and mem_mem_wr become 0. Data fields hold. No flag update.
- Flag derivation, computed locally:
  - Znew = (ex_alu_out == 0).
  - Nnew = ex_alu_out[WIDTH-1].
  - Vnew = ex_v.
- Flag update: only on a normal capture edge with ex_valid=1.
  - ALU codes 0000 (ADD) and 0010 (SUB): update Z, V and N.
  - Codes 0011, 0100, 0101, 0110 and 0111 (NAND, XOR, shifts): update Z only; V and N hold.
  - All other codes (PADDSB, LW, SW, LHB, LLB, 1100–1111): no update.
- Branch resolution is combinational; br_taken=0 whenever br_eval=0.
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1 or N=0
  - 101 LE: Z=1 or N=1
  - 110 OV: V=1
  - 111 always taken
- Flag source for resolution: the flag register, unless the optional bypass is compiled in.
- Width rule: Z compares all WIDTH bits. N is the MSB.

Optional Feature:
Macro FLAG_BYPASS_EN.
- Defined: when an EX instruction would update flags on this edge (ex_valid=1, stall=0, flush=0, flag-writing code), branch resolution uses the about-to-be-written values for the bits that code updates. Register values are used for the remaining bits. A branch in ID can then resolve in the same cycle as the flag-setting instruction in EX.
- Undefined: resolution uses only the flag register. The hazard unit must stall the branch one cycle behind any flag-writing instruction.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with prior flags=3'b111 and mem_valid=1 -> all mem_* outputs 0 and flags=000 immediately, before the next edge.
- ADD: ex_valid=1, ctrl=0000, ex_alu_out=16'h0000, ex_v=1 -> next cycle flags={1,1,0}, mem_alu_out=0000. Then SUB with out=16'h8001, v=0 -> flags={0,0,1}.
- Z-only update: flags={0,1,1}, XOR with out=16'h0000 -> flags={1,1,1}. Then LW with out=0 -> flags unchanged.
- Stall and flush: capture rd=5, reg_wr=1, then stall=1 for 2 cycles -> mem_rd=5 held and flags unchanged. Then flush=1 and stall=1 together -> mem_valid=0 and mem_reg_wr=0.
- Branch sweep: flags={0,0,1}, br_eval=1, br_cond 000..111 -> br_taken=1,0,0,1,0,1,0,1. With br_eval=0 -> br_taken=0.
- Bypass: flags={0,0,0}, SUB producing 0 in EX, br_cond=001 in the same cycle -> br_taken=1 with FLAG_BYPASS_EN defined, 0 without it.
